// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: datapath width,
// fetch FSM encoding and the word-alignment helper used on fetch addresses.
package inst_fetch_queue_pkg;

   localparam int COMMON_WIDTH = 32;
   localparam int ENTRY_WIDTH  = 2 * COMMON_WIDTH;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_WAIT  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_t;

   // Instruction memory is word addressed, so the two low bits are forced to zero.
   function automatic logic [COMMON_WIDTH-1:0] word_align(input logic [COMMON_WIDTH-1:0] addr);
      return addr & ~COMMON_WIDTH'(3);
   endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// The head entry is presented combinationally; flush empties it in one edge.
module fetch_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_WIDTH
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign rdata   = storage[rd_ptr];

   // Pointer and occupancy bookkeeping; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Entry storage, cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else if (do_push && !flush) begin
         storage[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues one memory request at a time for the
// current PC, buffers results for decode, and drops in-flight data on flush.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COMMON_WIDTH-1:0] pc_addr,
   input  logic                    flush,
   output logic                    fetch_stall,
   output logic                    imem_req,
   output logic [COMMON_WIDTH-1:0] imem_addr,
   input  logic                    imem_ack,
   input  logic [COMMON_WIDTH-1:0] imem_rdata,
   output logic                    id_valid,
   input  logic                    id_ready,
   output logic [COMMON_WIDTH-1:0] id_pc,
   output logic [COMMON_WIDTH-1:0] id_instr,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t           state;
   fetch_state_t           state_next;
   logic                   inhibit;
   logic [COMMON_WIDTH-1:0] addr_q;
   logic                   issue;
   logic                   push;
   logic                   pop;
   logic [ENTRY_WIDTH-1:0] head;

   // Issue decision, memory request outputs and next-state logic.
   always_comb begin
      issue       = (state == FS_IDLE) && !inhibit && !flush && (count < CW'(DEPTH));
      imem_req    = issue || (state != FS_IDLE);
      imem_addr   = (state == FS_IDLE) ? word_align(pc_addr) : addr_q;
      fetch_stall = !issue;
      push        = 1'b0;
      state_next  = state;
      case (state)
         FS_IDLE: begin
            if (issue) begin
               if (imem_ack) push = 1'b1;
               else          state_next = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (imem_ack) begin
               push       = !flush;
               state_next = FS_IDLE;
            end else if (flush) begin
               state_next = FS_DRAIN;
            end
         end
         FS_DRAIN: begin
            if (imem_ack) state_next = FS_IDLE;
         end
         default: state_next = FS_IDLE;
      endcase
   end

   // FSM state register; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FS_IDLE;
      else     state <= state_next;
   end

   // Hold off the very first fetch so the PC register's reset value is never requested.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) inhibit <= 1'b1;
      else     inhibit <= 1'b0;
   end

   // Capture the accepted address so it stays stable through wait states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        addr_q <= '0;
      else if (issue) addr_q <= word_align(pc_addr);
   end

   assign id_valid = (count != '0);
   assign pop      = id_valid && id_ready;
   assign id_pc    = head[ENTRY_WIDTH-1:COMMON_WIDTH];
   assign id_instr = head[COMMON_WIDTH-1:0];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({imem_addr, imem_rdata}),
      .rdata (head),
      .count (count)
   );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a fixed vector table, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pc_addr;
   logic        flush;
   logic        fetch_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [2:0]  count;

   int nVectors;
   int nMiscompares;

   // Reference model: a plain queue of fetched pairs plus an outstanding-request record.
   logic [63:0] mQ [$];
   logic        mInhibit;
   logic        mBusy;
   logic        mDiscard;
   logic [31:0] mAddr;
   logic        mIssue;
   logic        mReq;
   logic        mValid;
   logic [31:0] mAddrOut;

   typedef struct {
      logic [31:0] pc;
      logic        ack;
      logic        ready;
      logic        expReq;
      logic        expStall;
      logic [31:0] expAddr;
      logic [2:0]  expCount;
      logic [31:0] expPc;
   } vec_t;

   vec_t tbl [10];

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_addr     (pc_addr),
      .flush       (flush),
      .fetch_stall (fetch_stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_instr    (id_instr),
      .count       (count)
   );

   // Free-running clock, first rising edge at 5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instrOf(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nVectors++;
      if (got !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic resetModel();
      mQ.delete();
      mInhibit = 1'b1;
      mBusy    = 1'b0;
      mDiscard = 1'b0;
      mAddr    = '0;
   endtask

   // Drive one cycle of inputs during the low phase and compare DUT outputs against the model.
   task automatic applyStimulus(input logic [31:0] pc, input logic fl, input logic ack,
                                input logic [31:0] rd, input logic rdy);
      logic [63:0] headEntry;
      pc_addr    = pc;
      flush      = fl;
      imem_ack   = ack;
      imem_rdata = rd;
      id_ready   = rdy;
      #1;
      mIssue   = !mBusy && !mInhibit && !fl && (mQ.size() < DEPTH);
      mReq     = mIssue || mBusy;
      mAddrOut = mBusy ? mAddr : (pc & ~32'h3);
      mValid   = (mQ.size() != 0);
      checkOutput("imem_req", 32'(imem_req), 32'(mReq));
      checkOutput("fetch_stall", 32'(fetch_stall), 32'(!mIssue));
      checkOutput("id_valid", 32'(id_valid), 32'(mValid));
      checkOutput("count", 32'(count), 32'(mQ.size()));
      if (mReq) checkOutput("imem_addr", imem_addr, mAddrOut);
      if (mValid) begin
         headEntry = mQ[0];
         checkOutput("id_pc", id_pc, headEntry[63:32]);
         checkOutput("id_instr", id_instr, headEntry[31:0]);
      end
   endtask

   // Advance through one rising edge, updating the model from the inputs applied this cycle.
   task automatic clockEdge();
      logic pop;
      logic push;
      @(posedge clk);
      pop  = mValid && id_ready;
      push = imem_ack && (mIssue || (mBusy && !mDiscard && !flush));
      if (flush) mQ.delete();
      else begin
         if (pop)  void'(mQ.pop_front());
         if (push) mQ.push_back({mAddrOut, imem_rdata});
      end
      if (mIssue && !imem_ack) begin
         mBusy    = 1'b1;
         mDiscard = 1'b0;
         mAddr    = mAddrOut;
      end else if (mBusy && imem_ack) begin
         mBusy = 1'b0;
      end else if (mBusy && flush) begin
         mDiscard = 1'b1;
      end
      mInhibit = 1'b0;
      @(negedge clk);
   endtask

   task automatic cycle(input logic [31:0] pc, input logic fl, input logic ack,
                        input logic [31:0] rd, input logic rdy);
      applyStimulus(pc, fl, ack, rd, rdy);
      clockEdge();
   endtask

   // Main test sequence.
   initial begin
      logic [31:0] pcNext;
      logic        fl;
      nVectors     = 0;
      nMiscompares = 0;
      rst        = 1'b1;
      pc_addr    = '0;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      id_ready   = 1'b0;
      resetModel();

      // Zero-wait fill with decode stalled, then drain with sustained throughput.
      tbl[0] = '{32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 3'd0, 32'h0};
      tbl[1] = '{32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0};
      tbl[2] = '{32'h04, 1'b1, 1'b0, 1'b1, 1'b0, 32'h04, 3'd1, 32'h0};
      tbl[3] = '{32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 32'h08, 3'd2, 32'h0};
      tbl[4] = '{32'h0C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0C, 3'd3, 32'h0};
      tbl[5] = '{32'h10, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4, 32'h0};
      tbl[6] = '{32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 3'd4, 32'h0};
      tbl[7] = '{32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 3'd3, 32'h4};
      tbl[8] = '{32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 3'd3, 32'h8};
      tbl[9] = '{32'h18, 1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 3'd3, 32'hC};

      @(negedge clk);
      #2;
      checkOutput("reset_imem_req", 32'(imem_req), 32'd0);
      checkOutput("reset_fetch_stall", 32'(fetch_stall), 32'd1);
      checkOutput("reset_id_valid", 32'(id_valid), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_id_pc", id_pc, 32'd0);
      checkOutput("reset_id_instr", id_instr, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].pc, 1'b0, tbl[i].ack, instrOf(tbl[i].pc), tbl[i].ready);
         checkOutput($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].expReq));
         checkOutput($sformatf("tbl%0d_stall", i), 32'(fetch_stall), 32'(tbl[i].expStall));
         checkOutput($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].expCount));
         if (tbl[i].expReq) checkOutput($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].expAddr);
         if (tbl[i].expCount != 3'd0) begin
            checkOutput($sformatf("tbl%0d_pc", i), id_pc, tbl[i].expPc);
            checkOutput($sformatf("tbl%0d_instr", i), id_instr, instrOf(tbl[i].expPc));
         end
         clockEdge();
      end

      // Empty the queue, then a 3-cycle memory at 0x100 with the PC moving during the wait.
      $display("[TB] wait-state sequence");
      cycle(32'h18, 1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("ws_issue_addr", imem_addr, 32'h100);
      checkOutput("ws_issue_stall", 32'(fetch_stall), 32'd0);
      clockEdge();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h200, 1'b0, (i == 2), instrOf(32'h100), 1'b1);
         checkOutput($sformatf("ws%0d_addr", i), imem_addr, 32'h100);
         checkOutput($sformatf("ws%0d_stall", i), 32'(fetch_stall), 32'd1);
         checkOutput($sformatf("ws%0d_req", i), 32'(imem_req), 32'd1);
         clockEdge();
      end
      applyStimulus(32'h200, 1'b0, 1'b1, instrOf(32'h200), 1'b1);
      checkOutput("ws_done_pc", id_pc, 32'h100);
      checkOutput("ws_next_addr", imem_addr, 32'h200);
      clockEdge();

      // Flush while waiting: late data is dropped, redirect target issues after the ack.
      $display("[TB] flush-in-wait sequence");
      cycle(32'h20, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle(32'h400, 1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(32'h400, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
      checkOutput("fl_drain_addr", imem_addr, 32'h20);
      checkOutput("fl_drain_stall", 32'(fetch_stall), 32'd1);
      clockEdge();
      applyStimulus(32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("fl_no_push", 32'(id_valid), 32'd0);
      checkOutput("fl_redirect_req", 32'(imem_req), 32'd1);
      checkOutput("fl_redirect_addr", imem_addr, 32'h400);
      clockEdge();
      cycle(32'h404, 1'b0, 1'b1, instrOf(32'h400), 1'b0);

      // Three queued entries, then flush with same-cycle ack and pop.
      $display("[TB] flush-ack-pop sequence");
      cycle(32'h404, 1'b0, 1'b1, instrOf(32'h404), 1'b0);
      cycle(32'h408, 1'b0, 1'b1, instrOf(32'h408), 1'b0);
      cycle(32'h40C, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h800, 1'b1, 1'b1, instrOf(32'h40C), 1'b1);
      checkOutput("fap_count_before", 32'(count), 32'd3);
      clockEdge();
      applyStimulus(32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("fap_count_after", 32'(count), 32'd0);
      checkOutput("fap_valid_after", 32'(id_valid), 32'd0);
      checkOutput("fap_idle_issue", 32'(fetch_stall), 32'd0);
      clockEdge();

      // Asynchronous reset pulse between edges while a request is outstanding.
      $display("[TB] reset-in-wait sequence");
      cycle(32'h804, 1'b0, 1'b1, instrOf(32'h800), 1'b0);
      cycle(32'h804, 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(32'h808, 1'b0, 1'b0, 32'h0, 1'b0);
      #1 rst = 1'b1;
      #1;
      checkOutput("rstp_req", 32'(imem_req), 32'd0);
      checkOutput("rstp_valid", 32'(id_valid), 32'd0);
      checkOutput("rstp_count", 32'(count), 32'd0);
      rst = 1'b0;
      resetModel();
      @(posedge clk);
      mInhibit = 1'b0;
      @(negedge clk);
      applyStimulus(32'h900, 1'b0, 1'b1, instrOf(32'h900), 1'b1);
      checkOutput("rstp_resume_addr", imem_addr, 32'h900);
      clockEdge();

      // Randomized traffic against the model; upstream advances the PC only when accepted.
      $display("[TB] random sequence");
      pcNext = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         fl = ($urandom_range(0, 19) == 0);
         applyStimulus(pcNext | 32'($urandom_range(0, 3)), fl, 1'($urandom_range(0, 1)),
                       $urandom, ($urandom_range(0, 99) < 60));
         if (fl)          pcNext = {$urandom_range(0, 32'hFFFF), 16'h0} & ~32'h3;
         else if (mIssue) pcNext = pcNext + 32'd4;
         clockEdge();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
